mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 22 ++
 rtl/mem_req_fifo.sv | 65 ++++++
 rtl/mem_responder.sv | 156 +++++++++++++++
 tb/tb_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM encoding and queue entry layout.
package mem_responder_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    localparam int ENTRY_W = $bits(req_t);

endpackage

// File: rtl/mem_req_fifo.sv
// Request queue for mem_responder; when empty, a same-cycle push and pop
// hand the incoming entry straight through without storing it.
module mem_req_fifo
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  req_t din_i,
    output req_t dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PW = $clog2(DEPTH);

    req_t mem_q [DEPTH];

    logic [PW:0] wr_q, wr_d;
    logic [PW:0] rd_q, rd_d;
    logic        bypass;
    logic        do_wr;
    logic        do_rd;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) &&
                     (wr_q[PW-1:0] == rd_q[PW-1:0]);

    assign bypass = empty_o & push_i & pop_i;
    assign do_wr  = push_i & ~full_o & ~bypass;
    assign do_rd  = pop_i & ~empty_o;

    assign dout_o = empty_o ? din_i : mem_q[rd_q[PW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_wr) begin
            wr_d = wr_q + (PW+1)'(1);
        end
        if (do_rd) begin
            rd_d = rd_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_q[PW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Queued memory responder with fixed per-transaction latency.
// Optional sticky drop flag enabled by MEM_RESP_ERR_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int AWORDS  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic        read_q,
    input  logic        write_q,
    output logic [31:0] rsp_addr,
    output logic [31:0] rsp_data,
    output logic        bus_oe,
    output logic        is_bus_busy,
    output logic        read_dn,
    output logic        write_dn
`ifdef MEM_RESP_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int IW = $clog2(AWORDS);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              cur_q, cur_d;
    req_t              head;
    req_t              req_in;
    logic [31:0]       rsp_addr_q, rsp_addr_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rd_dn_q, rd_dn_d;
    logic              wr_dn_q, wr_dn_d;
    logic              req_any;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              avail;
    logic [IW-1:0]     cur_idx;
    logic [31:0]       mem_q [AWORDS];

    // A collision keeps the write; write_q alone decides the entry type.
    assign req_any = read_q | write_q;
    assign push    = req_any & ~full;
    assign req_in  = '{we: write_q, addr: addr, data: data_in};
    assign avail   = ~empty | push;
    assign cur_idx = cur_q.addr[IW-1:0];

    mem_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (req_in),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        pop        = 1'b0;
        rsp_addr_d = rsp_addr_q;
        rsp_data_d = rsp_data_q;
        rd_dn_d    = 1'b0;
        wr_dn_d    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (avail) begin
                    pop     = 1'b1;
                    cur_d   = head;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = S_DONE;
                    rsp_addr_d = cur_q.addr;
                    if (cur_q.we) begin
                        wr_dn_d = 1'b1;
                    end else begin
                        rd_dn_d    = 1'b1;
                        rsp_data_d = mem_q[cur_idx];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rd_dn_q    <= 1'b0;
            wr_dn_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_data_q <= rsp_data_d;
            rd_dn_q    <= rd_dn_d;
            wr_dn_q    <= wr_dn_d;
        end
    end

    // Storage is not reset; a reset during DONE still suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_DONE && cur_q.we) begin
            mem_q[cur_idx] <= cur_q.data;
        end
    end

    assign rsp_addr    = rsp_addr_q;
    assign rsp_data    = rsp_data_q;
    assign read_dn     = rd_dn_q;
    assign write_dn    = wr_dn_q;
    assign bus_oe      = rd_dn_q;
    assign is_bus_busy = (state_q != S_IDLE);

`ifdef MEM_RESP_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (req_any && (full || (read_q && write_q))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: schedule-based model plus
// directed scenarios with literal expectations.
module tb_mem_responder;

    localparam int L = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic        read_q = 1'b0;
    logic        write_q = 1'b0;
    logic [31:0] rsp_addr;
    logic [31:0] rsp_data;
    logic        bus_oe;
    logic        is_bus_busy;
    logic        read_dn;
    logic        write_dn;
`ifdef MEM_RESP_ERR_EN
    logic        err;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    mem_responder #(
        .LATENCY(L),
        .DEPTH  (D),
        .AWORDS (256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data_in    (data_in),
        .read_q     (read_q),
        .write_q    (write_q),
        .rsp_addr   (rsp_addr),
        .rsp_data   (rsp_data),
        .bus_oe     (bus_oe),
        .is_bus_busy(is_bus_busy),
        .read_dn    (read_dn),
        .write_dn   (write_dn)
`ifdef MEM_RESP_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Model: each accepted request gets a completion cycle from the
    // schedule rule; queue occupancy is derived from those schedules.
    int          t_enq[$];
    int          t_done[$];
    bit          t_we[$];
    logic [31:0] t_addr[$];
    logic [31:0] t_data[$];
    int          last_done;
    logic [31:0] mm[256];
    bit          mk[256];
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    bit          exp_dk;
    bit          exp_err;

    initial begin
        for (int i = 0; i < 256; i++) mk[i] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                t_enq.delete();
                t_done.delete();
                t_we.delete();
                t_addr.delete();
                t_data.delete();
                last_done = -100;
                exp_addr  = '0;
                exp_data  = '0;
                exp_dk    = 1'b1;
                exp_err   = 1'b0;
            end else begin
                bit e_rd, e_wr, e_busy, wdo;
                int occ, nd;
                logic [7:0] wi;
                logic [31:0] wd;
                e_rd = 0; e_wr = 0; e_busy = 0; wdo = 0;
                wi = '0; wd = '0;
                foreach (t_done[i]) begin
                    if (t_done[i] - L - 1 < cyc && cyc <= t_done[i])
                        e_busy = 1;
                    if (t_done[i] == cyc) begin
                        exp_addr = t_addr[i];
                        if (t_we[i]) begin
                            e_wr = 1; wdo = 1;
                            wi = t_addr[i][7:0]; wd = t_data[i];
                        end else begin
                            e_rd = 1;
                            exp_data = mm[t_addr[i][7:0]];
                            exp_dk = mk[t_addr[i][7:0]];
                        end
                    end
                end
                chk("read_dn", 32'(read_dn), 32'(e_rd));
                chk("write_dn", 32'(write_dn), 32'(e_wr));
                chk("bus_oe", 32'(bus_oe), 32'(e_rd));
                chk("busy", 32'(is_bus_busy), 32'(e_busy));
                chk("rsp_addr", rsp_addr, exp_addr);
                if (exp_dk) chk("rsp_data", rsp_data, exp_data);
`ifdef MEM_RESP_ERR_EN
                chk("err", 32'(err), 32'(exp_err));
`endif
                if (write_dn === 1'b1) wr_cnt++;
                if (read_dn === 1'b1) rd_cnt++;
                if (wdo) begin
                    mm[wi] = wd;
                    mk[wi] = 1'b1;
                end
                if (read_q || write_q) begin
                    occ = 0;
                    foreach (t_enq[i])
                        if (t_enq[i] < cyc && t_done[i] - L - 1 >= cyc) occ++;
                    if (read_q && write_q) exp_err = 1'b1;
                    if (occ >= D) begin
                        exp_err = 1'b1;
                    end else begin
                        nd = cyc + 1 + L;
                        if (last_done + L + 1 > nd) nd = last_done + L + 1;
                        t_enq.push_back(cyc);
                        t_done.push_back(nd);
                        t_we.push_back(write_q);
                        t_addr.push_back(addr);
                        t_data.push_back(data_in);
                        last_done = nd;
                    end
                end
            end
        end
    end

    task automatic req(input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, output int t);
        read_q = r; write_q = w; addr = a; data_in = d;
        t = cyc;
        @(posedge clk);
        #1;
        read_q = 0; write_q = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_dn(input bit rd, output int at,
                           output logic [31:0] a, output logic [31:0] dt);
        at = -1; a = '0; dt = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((rd ? read_dn : write_dn) === 1'b1) begin
                at = cyc; a = rsp_addr; dt = rsp_data;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string n, input logic [31:0] a,
                            input logic [31:0] expd);
        int t, at;
        logic [31:0] ra, rdd;
        req(1, 0, a, 0, t);
        wait_dn(1, at, ra, rdd);
        chk({n, "_lat"}, 32'(at - t), 32'd3);
        chk({n, "_addr"}, ra, a);
        chk({n, "_data"}, rdd, expd);
    endtask

    initial begin
        int t0, t1, at, w0, r0;
        logic [31:0] ra, rdd;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_addr", rsp_addr, 32'h0);
        chk("rst_data", rsp_data, 32'h0);
        chk("rst_busy", 32'(is_bus_busy), 32'd0);
        chk("rst_dn", 32'({read_dn, write_dn, bus_oe}), 32'd0);
`ifdef MEM_RESP_ERR_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
        @(posedge clk);
        #1;

        // write then read of the same word
        req(0, 1, 32'h10, 32'h1234_5678, t0);
        req(1, 0, 32'h10, 32'h0, t1);
        wait_dn(0, at, ra, rdd);
        chk("wr_lat", 32'(at - t0), 32'd3);
        chk("wr_addr", ra, 32'h10);
        wait_dn(1, at, ra, rdd);
        chk("rd_lat", 32'(at - t0), 32'd6);
        chk("rd_addr", ra, 32'h10);
        chk("rd_data", rdd, 32'h1234_5678);
        idle(3);

        // back-to-back reads complete in order, 3 cycles apart
        req(0, 1, 32'h03, 32'h33, t0);
        req(0, 1, 32'h04, 32'h44, t0);
        idle(10);
        req(1, 0, 32'h03, 32'h0, t0);
        req(1, 0, 32'h04, 32'h0, t1);
        wait_dn(1, at, ra, rdd);
        chk("b2b_lat0", 32'(at - t0), 32'd3);
        chk("b2b_addr0", ra, 32'h03);
        chk("b2b_data0", rdd, 32'h33);
        wait_dn(1, at, ra, rdd);
        chk("b2b_lat1", 32'(at - t0), 32'd6);
        chk("b2b_addr1", ra, 32'h04);
        chk("b2b_data1", rdd, 32'h44);
        idle(3);

        // seven back-to-back writes: the seventh finds the queue full
        w0 = wr_cnt;
        for (int i = 0; i < 7; i++)
            req(0, 1, 32'h40 + 32'(i), 32'h100 + 32'(i), t0);
        idle(30);
        chk("ovf_wr_count", 32'(wr_cnt - w0), 32'd6);
`ifdef MEM_RESP_ERR_EN
        chk("ovf_err", 32'(err), 32'd1);
`endif
        rd_check("ovf_rd45", 32'h45, 32'h105);
        idle(2);

        // collision: write wins, read dropped
        w0 = wr_cnt;
        r0 = rd_cnt;
        req(1, 1, 32'h20, 32'hAA, t0);
        idle(10);
        chk("col_wr_count", 32'(wr_cnt - w0), 32'd1);
        chk("col_rd_count", 32'(rd_cnt - r0), 32'd0);
        rd_check("col_rd20", 32'h20, 32'hAA);
        idle(2);

        // reset during WAIT abandons the write
        req(0, 1, 32'h30, 32'h5555, t0);
        idle(8);
        w0 = wr_cnt;
        req(0, 1, 32'h30, 32'h9999, t0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("mrst_addr", rsp_addr, 32'h0);
        chk("mrst_data", rsp_data, 32'h0);
        chk("mrst_busy", 32'(is_bus_busy), 32'd0);
        chk("mrst_dn", 32'({read_dn, write_dn, bus_oe}), 32'd0);
`ifdef MEM_RESP_ERR_EN
        chk("mrst_err", 32'(err), 32'd0);
`endif
        idle(8);
        chk("mrst_wr_count", 32'(wr_cnt - w0), 32'd0);
        rd_check("mrst_rd30", 32'h30, 32'h5555);
        idle(2);

        // upper address bits ignored for indexing, echoed in rsp_addr
        req(0, 1, 32'h0000_0105, 32'hBEEF, t0);
        idle(6);
        rd_check("alias05", 32'h05, 32'hBEEF);
        idle(1);
        rd_check("alias105", 32'h0000_0105, 32'hBEEF);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
